// File: rtl/vga_frame_checker.sv
// Per-frame VGA statistics: classifies strobed pixels, measures line lengths, and
// reports each completed frame over a valid/ready handshake.
module vga_frame_checker #(
  parameter int unsigned       RGB_W    = 8,
  parameter int unsigned       CLK_DIV  = 2,
  parameter logic [RGB_W-1:0]  FG_COLOR = 8'h1C,
  parameter logic [RGB_W-1:0]  BG_COLOR = 8'h00,
  parameter int unsigned       CNT_W    = 20,
  parameter int unsigned       LINE_W   = 12
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [RGB_W-1:0]  RGB,
  input  logic              HSYNC,
  input  logic              VSYNC,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [15:0]       stat_frame,
  output logic [CNT_W-1:0]  stat_fg,
  output logic [CNT_W-1:0]  stat_bg,
  output logic [CNT_W-1:0]  stat_other,
  output logic [LINE_W-1:0] stat_lines,
  output logic [LINE_W-1:0] stat_line_px,
  output logic              stat_line_err,
  output logic              stat_drop
);

  localparam int unsigned     DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StCapture} state_e;

  state_e state_q, state_d;
  logic   capture;

  logic [DIV_W-1:0]  div_q;
  logic [RGB_W-1:0]  rgb_q;
  logic              hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic              strobe, hs_fall, vs_fall;

  logic [CNT_W-1:0]  fg_q, bg_q, other_q, fg_d, bg_d, other_d;
  logic [LINE_W-1:0] lines_q, line_px_q, line_cnt_q, lines_d, line_px_d, line_cnt_d;
  logic              line_err_q, line_err_d;
  logic [15:0]       frame_q;
  logic              pix, hs_end, vs_end, is_fg, is_bg;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LINE_W-1:0] inc_line(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + LINE_W'(1);
  endfunction

  assign strobe  = (div_q == DIV_MAX);
  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle && vs_fall) state_d = StCapture;
  end

  always_comb begin
    capture = (state_q == StCapture);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_q     <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      div_q     <= strobe ? '0 : div_q + DIV_W'(1);
      rgb_q     <= RGB;
      hs_q      <= HSYNC;
      hs_prev_q <= hs_q;
      vs_q      <= VSYNC;
      vs_prev_q <= vs_q;
    end
  end

  // Closing values: this cycle's strobe and line end are folded in before any report.
  always_comb begin
    pix        = capture && strobe;
    hs_end     = capture && hs_fall;
    vs_end     = capture && vs_fall;
    is_fg      = (rgb_q == FG_COLOR);
    is_bg      = !is_fg && (rgb_q == BG_COLOR);
    fg_d       = fg_q;
    bg_d       = bg_q;
    other_d    = other_q;
    line_cnt_d = line_cnt_q;
    lines_d    = lines_q;
    line_px_d  = line_px_q;
    line_err_d = line_err_q;
    if (pix) begin
      if (is_fg)      fg_d    = inc_cnt(fg_q);
      else if (is_bg) bg_d    = inc_cnt(bg_q);
      else            other_d = inc_cnt(other_q);
      line_cnt_d = inc_line(line_cnt_q);
    end
    if (hs_end) begin
      lines_d = inc_line(lines_q);
      if (lines_q == '0)                  line_px_d  = line_cnt_d;
      else if (line_cnt_d != line_px_q)   line_err_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || vs_end) begin
      fg_q       <= '0;
      bg_q       <= '0;
      other_q    <= '0;
      lines_q    <= '0;
      line_px_q  <= '0;
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else begin
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      other_q    <= other_d;
      lines_q    <= lines_d;
      line_px_q  <= line_px_d;
      line_cnt_q <= hs_end ? '0 : line_cnt_d;
      line_err_q <= line_err_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      frame_q       <= '0;
      stat_valid    <= 1'b0;
      stat_frame    <= '0;
      stat_fg       <= '0;
      stat_bg       <= '0;
      stat_other    <= '0;
      stat_lines    <= '0;
      stat_line_px  <= '0;
      stat_line_err <= 1'b0;
      stat_drop     <= 1'b0;
    end else if (vs_end) begin
      frame_q       <= frame_q + 16'd1;
      stat_valid    <= 1'b1;
      stat_frame    <= frame_q;
      stat_fg       <= fg_d;
      stat_bg       <= bg_d;
      stat_other    <= other_d;
      stat_lines    <= lines_d;
      stat_line_px  <= line_px_d;
      stat_line_err <= line_err_d;
      // An unaccepted report is being overwritten.
      if (stat_valid && !stat_ready) stat_drop <= 1'b1;
    end else if (stat_valid && stat_ready) begin
      stat_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker: table of frames checked through a report scoreboard,
// plus back-pressure, mid-frame reset and saturation sequences.
module tb_vga_frame_checker;

  localparam int DIV = 2;
  localparam int NV  = 5;

  logic        HCLK = 1'b0;
  logic        HRESET, HSYNC, VSYNC, stat_ready;
  logic [7:0]  RGB;

  logic        stat_valid, stat_line_err, stat_drop;
  logic [15:0] stat_frame;
  logic [19:0] stat_fg, stat_bg, stat_other;
  logic [11:0] stat_lines, stat_line_px;

  logic        sat_valid, sat_line_err, sat_drop;
  logic [15:0] sat_frame;
  logic [3:0]  sat_fg, sat_bg, sat_other;
  logic [11:0] sat_lines, sat_line_px;

  vga_frame_checker dut (
    .HCLK(HCLK), .HRESET(HRESET), .RGB(RGB), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_frame(stat_frame),
    .stat_fg(stat_fg), .stat_bg(stat_bg), .stat_other(stat_other),
    .stat_lines(stat_lines), .stat_line_px(stat_line_px),
    .stat_line_err(stat_line_err), .stat_drop(stat_drop)
  );

  vga_frame_checker #(.CNT_W(4)) dut_sat (
    .HCLK(HCLK), .HRESET(HRESET), .RGB(RGB), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .stat_valid(sat_valid), .stat_ready(stat_ready), .stat_frame(sat_frame),
    .stat_fg(sat_fg), .stat_bg(sat_bg), .stat_other(sat_other),
    .stat_lines(sat_lines), .stat_line_px(sat_line_px),
    .stat_line_err(sat_line_err), .stat_drop(sat_drop)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int frame, fg, bg, other, lines, line_px, err, drop;
  } rep_t;

  typedef struct {
    int n;
    int len [4];
    int fg, bg, other, lines, line_px, err;
  } vec_t;

  rep_t sb[$];
  vec_t tbl[NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted report is compared against the oldest expectation.
  always @(negedge HCLK) begin
    if (!HRESET && stat_valid && stat_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        rep_t e;
        e = sb.pop_front();
        chk("frame", stat_frame, e.frame);
        chk("fg", stat_fg, e.fg);
        chk("bg", stat_bg, e.bg);
        chk("other", stat_other, e.other);
        chk("lines", stat_lines, e.lines);
        chk("line_px", stat_line_px, e.line_px);
        chk("line_err", stat_line_err, e.err);
        chk("drop", stat_drop, e.drop);
      end
    end
  end

  task automatic set_vec(input int i, input int n, input int l0, input int l1, input int l2,
                         input int l3, input int fg, input int bg, input int oth,
                         input int lines, input int lpx, input int err);
    tbl[i].n = n;
    tbl[i].len[0] = l0; tbl[i].len[1] = l1; tbl[i].len[2] = l2; tbl[i].len[3] = l3;
    tbl[i].fg = fg; tbl[i].bg = bg; tbl[i].other = oth;
    tbl[i].lines = lines; tbl[i].line_px = lpx; tbl[i].err = err;
  endtask

  task automatic push_exp(input int frame, input int fg, input int bg, input int oth,
                          input int lines, input int lpx, input int err, input int drop);
    rep_t r;
    r.frame = frame; r.fg = fg; r.bg = bg; r.other = oth;
    r.lines = lines; r.line_px = lpx; r.err = err; r.drop = drop;
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Leaves the divider phase such that a strobe lands on the last cycle of every pixel.
  task automatic do_reset();
    HRESET = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; RGB = 8'h55;
    tick();
    @(negedge HCLK);
    chk("rst_valid", stat_valid, 0);
    chk("rst_frame", stat_frame, 0);
    chk("rst_fg", stat_fg, 0);
    chk("rst_lines", stat_lines, 0);
    chk("rst_drop", stat_drop, 0);
    tick();
    HRESET = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_capture();
    VSYNC = 1'b0;
    tick();
    VSYNC = 1'b1;
  endtask

  task automatic send_line(input int len, input bit last, input bit all_fg);
    for (int p = 0; p < len; p++) begin
      RGB = all_fg ? 8'h1C : (p < 6) ? 8'h1C : (p < 9) ? 8'h00 : 8'hFF;
      for (int c = 0; c < DIV; c++) begin
        if (p == len - 1 && c == DIV - 1) begin
          HSYNC = 1'b0;
          if (last) VSYNC = 1'b0;
        end
        tick();
        HSYNC = 1'b1;
        VSYNC = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int idx);
    for (int k = 0; k < tbl[idx].n; k++) send_line(tbl[idx].len[k], k == tbl[idx].n - 1, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("pending_reports", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int got;
    HRESET = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; RGB = 8'h00; stat_ready = 1'b1;

    set_vec(0, 4, 10, 10, 10, 10, 24, 12, 4, 4, 10, 0);
    set_vec(1, 4, 10, 10, 9, 10, 24, 12, 3, 4, 10, 1);
    set_vec(2, 2, 7, 7, 0, 0, 12, 2, 0, 2, 7, 0);
    set_vec(3, 1, 10, 0, 0, 0, 6, 3, 1, 1, 10, 0);
    set_vec(4, 3, 5, 10, 10, 0, 17, 6, 2, 3, 5, 1);

    // Back-to-back frames; each ends with coincident HSYNC/VSYNC falls and a strobe.
    do_reset();
    start_capture();
    for (int i = 0; i < NV; i++) begin
      push_exp(i, tbl[i].fg, tbl[i].bg, tbl[i].other, tbl[i].lines, tbl[i].line_px,
               tbl[i].err, 0);
      send_frame(i);
    end
    wait_drain();

    // Back-pressure: second report overwrites the first and flags a drop.
    do_reset();
    start_capture();
    stat_ready = 1'b0;
    send_frame(0);
    push_exp(1, 6, 3, 1, 1, 10, 0, 1);
    send_frame(3);
    tick();
    @(negedge HCLK);
    chk("bp_valid", stat_valid, 1);
    chk("bp_frame", stat_frame, 1);
    chk("bp_fg", stat_fg, 6);
    chk("bp_drop", stat_drop, 1);
    tick(); tick(); tick();
    @(negedge HCLK);
    chk("bp_hold_valid", stat_valid, 1);
    chk("bp_hold_frame", stat_frame, 1);
    chk("bp_hold_fg", stat_fg, 6);
    chk("bp_hold_other", stat_other, 1);
    tick();
    stat_ready = 1'b1;
    tick();
    @(negedge HCLK);
    chk("bp_valid_clear", stat_valid, 0);
    chk("bp_pending", sb.size(), 0);

    // Mid-frame reset discards the partial frame; IDLE lines are ignored.
    do_reset();
    start_capture();
    send_line(10, 1'b0, 1'b0);
    send_line(10, 1'b0, 1'b0);
    do_reset();
    send_line(10, 1'b0, 1'b0);
    send_line(10, 1'b0, 1'b0);
    start_capture();
    push_exp(0, 24, 12, 4, 4, 10, 0, 0);
    send_frame(0);
    wait_drain();
    for (int i = 0; i < 30; i++) tick();

    // Saturation on the narrow-counter instance.
    do_reset();
    start_capture();
    push_exp(0, 20, 0, 0, 1, 20, 0, 0);
    send_line(20, 1'b1, 1'b1);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge HCLK);
      got = sat_valid;
    end
    chk("sat_valid", got, 1);
    chk("sat_frame", sat_frame, 0);
    chk("sat_fg", sat_fg, 15);
    chk("sat_bg", sat_bg, 0);
    chk("sat_other", sat_other, 0);
    chk("sat_lines", sat_lines, 1);
    chk("sat_line_px", sat_line_px, 20);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
